// File: rtl/div_iter_if.sv
// Operand/result handshake bundle for the iterative fixed-point divider.
// The master drives operands and result-ready; the slave (divider) drives the rest.
interface div_iter_if #(
  parameter int D_W = 16
);
  logic           I_VLD;
  logic           O_RDY;
  logic [D_W-1:0] I_DIVIDEND;
  logic [D_W-1:0] I_DIVISOR;
  logic           O_VLD;
  logic           I_RDY;
  logic [D_W-1:0] O_QUOTIENT;
  logic           O_DIV0;
  logic           O_OVF;

  modport master (
    output I_VLD, I_DIVIDEND, I_DIVISOR, I_RDY,
    input  O_RDY, O_VLD, O_QUOTIENT, O_DIV0, O_OVF
  );

  modport slave (
    input  I_VLD, I_DIVIDEND, I_DIVISOR, I_RDY,
    output O_RDY, O_VLD, O_QUOTIENT, O_DIV0, O_OVF
  );
endinterface

// File: rtl/div_iter.sv
// Signed Qm.FRAC_BIT divider: restoring division on magnitudes, BITS_PER_CYC bits per cycle,
// then sign and saturation in one extra cycle so latency is fixed at N_ITER+1 edges.
//   state  | meaning
//   S_IDLE | ready for operands
//   S_DIV  | N_ITER iteration cycles, then one finalize cycle
//   S_OUT  | result held until I_RDY
module div_iter #(
  parameter int D_W          = 16,
  parameter int FRAC_BIT     = 13,
  parameter int BITS_PER_CYC = 7
) (
  input logic       I_CLK,
  input logic       I_RST_N,
  div_iter_if.slave bus
);
  localparam int Q_W    = D_W + FRAC_BIT;
  localparam int N_ITER = (Q_W + BITS_PER_CYC - 1) / BITS_PER_CYC;
  localparam int CNT_W  = $clog2(N_ITER + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_ITER);
  localparam logic [Q_W-1:0]   LIM_POS  = {{(Q_W-D_W+1){1'b0}}, {(D_W-1){1'b1}}};
  localparam logic [Q_W-1:0]   LIM_NEG  = {{(Q_W-D_W){1'b0}}, 1'b1, {(D_W-1){1'b0}}};
  localparam logic [D_W-1:0]   Q_MAX    = {1'b0, {(D_W-1){1'b1}}};
  localparam logic [D_W-1:0]   Q_MIN    = {1'b1, {(D_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_OUT} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [Q_W-1:0]   num_q, quo_q;
  logic [D_W:0]     rem_q;
  logic [D_W-1:0]   den_q;
  logic             a_neg_q, neg_q, div0_q;
  logic             vld_q, div0_out_q, ovf_q;
  logic [D_W-1:0]   res_q;

  logic [Q_W-1:0]   num_d, quo_d;
  logic [D_W:0]     rem_d;
  logic [D_W-1:0]   res_d;
  logic             ovf_d;
  logic [D_W-1:0]   a_mag, b_mag;

  // Magnitudes kept at D_W bits unsigned so the most negative operand is exact.
  assign a_mag = bus.I_DIVIDEND[D_W-1] ? (~bus.I_DIVIDEND + 1'b1) : bus.I_DIVIDEND;
  assign b_mag = bus.I_DIVISOR[D_W-1]  ? (~bus.I_DIVISOR + 1'b1)  : bus.I_DIVISOR;

  always_comb begin
    rem_d = rem_q;
    num_d = num_q;
    quo_d = quo_q;
    for (int j = 0; j < BITS_PER_CYC; j++) begin
      // The last iteration only resolves whatever bits remain of Q_W.
      if (int'(cnt_q) * BITS_PER_CYC + j < Q_W) begin
        rem_d = {rem_d[D_W-1:0], num_d[Q_W-1]};
        num_d = {num_d[Q_W-2:0], 1'b0};
        if (rem_d >= {1'b0, den_q}) begin
          rem_d = rem_d - {1'b0, den_q};
          quo_d = {quo_d[Q_W-2:0], 1'b1};
        end else begin
          quo_d = {quo_d[Q_W-2:0], 1'b0};
        end
      end
    end
  end

  always_comb begin
    res_d = quo_q[D_W-1:0];
    ovf_d = 1'b0;
    if (div0_q) begin
      res_d = a_neg_q ? Q_MIN : Q_MAX;
      ovf_d = 1'b1;
    end else if (!neg_q) begin
      if (quo_q > LIM_POS) begin
        res_d = Q_MAX;
        ovf_d = 1'b1;
      end
    end else if (quo_q > LIM_NEG) begin
      res_d = Q_MIN;
      ovf_d = 1'b1;
    end else begin
      res_d = -quo_q[D_W-1:0];
    end
  end

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      num_q      <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      den_q      <= '0;
      a_neg_q    <= 1'b0;
      neg_q      <= 1'b0;
      div0_q     <= 1'b0;
      vld_q      <= 1'b0;
      div0_out_q <= 1'b0;
      ovf_q      <= 1'b0;
      res_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.I_VLD) begin
            num_q   <= {a_mag, {FRAC_BIT{1'b0}}};
            den_q   <= b_mag;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            a_neg_q <= bus.I_DIVIDEND[D_W-1];
            neg_q   <= bus.I_DIVIDEND[D_W-1] ^ bus.I_DIVISOR[D_W-1];
            div0_q  <= (bus.I_DIVISOR == '0);
            state_q <= S_DIV;
          end
        end
        S_DIV: begin
          if (cnt_q == CNT_LAST) begin
            res_q      <= res_d;
            ovf_q      <= ovf_d;
            div0_out_q <= div0_q;
            vld_q      <= 1'b1;
            state_q    <= S_OUT;
          end else begin
            num_q <= num_d;
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_OUT: begin
          if (bus.I_RDY) begin
            vld_q      <= 1'b0;
            res_q      <= '0;
            ovf_q      <= 1'b0;
            div0_out_q <= 1'b0;
            state_q    <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.O_RDY      = (state_q == S_IDLE);
  assign bus.O_VLD      = vld_q;
  assign bus.O_QUOTIENT = res_q;
  assign bus.O_DIV0     = div0_out_q;
  assign bus.O_OVF      = ovf_q;
endmodule

// File: tb/tb_div_iter.sv
// Scoreboard bench for div_iter: directed vectors push expectations, a monitor pops on O_VLD.
module tb_div_iter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  div_iter_if #(.D_W(16)) dif ();
  div_iter_if #(.D_W(16)) dif1 ();
  div_iter_if #(.D_W(16)) dif29 ();

  div_iter u_dut (.I_CLK(clk), .I_RST_N(rst_n), .bus(dif.slave));
  div_iter #(.BITS_PER_CYC(1))  u_dut1  (.I_CLK(clk), .I_RST_N(rst_n), .bus(dif1.slave));
  div_iter #(.BITS_PER_CYC(29)) u_dut29 (.I_CLK(clk), .I_RST_N(rst_n), .bus(dif29.slave));

  typedef struct {
    logic [15:0] q;
    logic        d0;
    logic        ov;
    int          acc;
  } exp_t;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic        d0;
    logic        ov;
  } vec_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   last_acc = 0;
  logic vld_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (dif.O_VLD && !vld_prev) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_vld: actual quotient=%0h with no pending operation", dif.O_QUOTIENT);
      end else begin
        e = sb.pop_front();
        chk("quotient", dif.O_QUOTIENT, e.q);
        chk("div0", dif.O_DIV0, e.d0);
        chk("ovf", dif.O_OVF, e.ov);
        chk("latency", cyc - e.acc, 6);
      end
    end
    vld_prev = dif.O_VLD;
  end

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [15:0] q,
                       input logic d0, input logic ov, input bit push);
    int n = 0;
    @(negedge clk);
    while (!dif.O_RDY && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!dif.O_RDY) begin
      chk("rdy_timeout", dif.O_RDY, 1);
      return;
    end
    dif.I_VLD      = 1'b1;
    dif.I_DIVIDEND = a;
    dif.I_DIVISOR  = b;
    @(posedge clk);
    #1;
    last_acc = cyc;
    if (push) sb.push_back('{q, d0, ov, cyc});
    dif.I_VLD = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb.size(), 0);
  endtask

  vec_t vecs[12];

  initial begin
    int n;
    int seen;
    int acc0;
    vecs = '{
      '{16'h2000, 16'h4000, 16'h1000, 1'b0, 1'b0},
      '{16'hD000, 16'h1000, 16'hA000, 1'b0, 1'b0},
      '{16'h2000, 16'h6000, 16'h0AAA, 1'b0, 1'b0},
      '{16'hE000, 16'h6000, 16'hF556, 1'b0, 1'b0},
      '{16'h6000, 16'h0800, 16'h7FFF, 1'b0, 1'b1},
      '{16'h8000, 16'hE000, 16'h7FFF, 1'b0, 1'b1},
      '{16'hE000, 16'h0000, 16'h8000, 1'b1, 1'b1},
      '{16'h0000, 16'h1234, 16'h0000, 1'b0, 1'b0},
      '{16'h8000, 16'h2000, 16'h8000, 1'b0, 1'b0},
      '{16'h2000, 16'h0000, 16'h7FFF, 1'b1, 1'b1},
      '{16'h0000, 16'hF000, 16'h0000, 1'b0, 1'b0},
      '{16'h7FFF, 16'h7FFF, 16'h2000, 1'b0, 1'b0}
    };
    dif.I_VLD = 1'b0;   dif.I_DIVIDEND = '0;   dif.I_DIVISOR = '0;   dif.I_RDY = 1'b1;
    dif1.I_VLD = 1'b0;  dif1.I_DIVIDEND = '0;  dif1.I_DIVISOR = '0;  dif1.I_RDY = 1'b1;
    dif29.I_VLD = 1'b0; dif29.I_DIVIDEND = '0; dif29.I_DIVISOR = '0; dif29.I_RDY = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_vld", dif.O_VLD, 0);
    chk("rst_q", dif.O_QUOTIENT, 0);
    chk("rst_div0", dif.O_DIV0, 0);
    chk("rst_ovf", dif.O_OVF, 0);
    chk("rst_rdy", dif.O_RDY, 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rdy_after_rst", dif.O_RDY, 1);

    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].d0, vecs[i].ov, 1'b1);
      if (i == 0) acc0 = last_acc;
      if (i == 1) chk("throughput", last_acc - acc0, 8);
    end
    drain();

    // Output held under back-pressure; operand pulses must be ignored.
    dif.I_RDY = 1'b0;
    issue(16'h6000, 16'h0800, 16'h7FFF, 1'b0, 1'b1, 1'b1);
    n = 0;
    while (!dif.O_VLD && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("hold_vld_seen", dif.O_VLD, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_q", dif.O_QUOTIENT, 16'h7FFF);
      chk("hold_vld", dif.O_VLD, 1);
      chk("hold_ovf", dif.O_OVF, 1);
      chk("hold_rdy", dif.O_RDY, 0);
      dif.I_VLD      = (i % 2 == 0);
      dif.I_DIVIDEND = 16'h1000;
      dif.I_DIVISOR  = 16'h1000;
    end
    @(negedge clk);
    dif.I_VLD = 1'b0;
    dif.I_RDY = 1'b1;
    @(posedge clk);
    #1;
    chk("release_rdy", dif.O_RDY, 1);
    chk("release_vld", dif.O_VLD, 0);
    chk("release_ovf", dif.O_OVF, 0);
    chk("release_div0", dif.O_DIV0, 0);
    repeat (12) @(negedge clk);

    // Reset during the third S_DIV cycle discards the operation.
    issue(16'h6000, 16'h0800, 16'h7FFF, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_vld", dif.O_VLD, 0);
    chk("abort_q", dif.O_QUOTIENT, 0);
    chk("abort_div0", dif.O_DIV0, 0);
    chk("abort_ovf", dif.O_OVF, 0);
    chk("abort_rdy", dif.O_RDY, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dif.O_VLD) seen++;
    end
    chk("abort_no_vld", seen, 0);

    // One bit per cycle: 29 iterations.
    @(negedge clk);
    dif1.I_VLD = 1'b1; dif1.I_DIVIDEND = 16'h2000; dif1.I_DIVISOR = 16'h4000;
    @(posedge clk);
    #1;
    acc0 = cyc;
    dif1.I_VLD = 1'b0;
    n = 0;
    while (!dif1.O_VLD && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bpc1_vld", dif1.O_VLD, 1);
    chk("bpc1_latency", cyc - acc0, 30);
    chk("bpc1_q", dif1.O_QUOTIENT, 16'h1000);
    chk("bpc1_flags", {dif1.O_DIV0, dif1.O_OVF}, 2'b00);

    // All 29 bits in a single iteration.
    @(negedge clk);
    dif29.I_VLD = 1'b1; dif29.I_DIVIDEND = 16'h2000; dif29.I_DIVISOR = 16'h4000;
    @(posedge clk);
    #1;
    acc0 = cyc;
    dif29.I_VLD = 1'b0;
    n = 0;
    while (!dif29.O_VLD && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bpc29_vld", dif29.O_VLD, 1);
    chk("bpc29_latency", cyc - acc0, 2);
    chk("bpc29_q", dif29.O_QUOTIENT, 16'h1000);
    chk("bpc29_flags", {dif29.O_DIV0, dif29.O_OVF}, 2'b00);

    repeat (4) @(negedge clk);
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
